keypad_fifo: RTL and testbench



---
 rtl/keypad_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/keypad_fifo.sv | 99 +++++++++
 tb/tb_keypad_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared register map and bit layout for the keypad key buffer.
package keypad_pkg;

  // Register offsets inside the keypad window
  localparam logic [11:0] OFF_DATA   = 12'd0;
  localparam logic [11:0] OFF_STATUS = 12'd1;
  localparam logic [11:0] OFF_CTRL   = 12'd2;

  // STATUS bit positions
  localparam int ST_NE      = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_FLUSH = 0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL
  } reg_sel_e;

  // Assemble the STATUS word; unlisted bits stay zero
  function automatic logic [15:0] status_word(input logic ne, input logic full,
                                              input logic ovf, input logic [3:0] cnt);
    logic [15:0] w;
    w                         = '0;
    w[ST_NE]                  = ne;
    w[ST_FULL]                = full;
    w[ST_OVF]                 = ovf;
    w[ST_CNT_LSB +: 4]        = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and an explicit count.
// Flush overrides push and pop; a pop on empty is ignored; a push when full is
// accepted only if a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [3:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic [W-1:0]  r_mem [DEPTH];

  logic w_pop;
  logic w_push;

  assign empty  = (r_count == 4'd0);
  assign full   = (r_count == 4'(DEPTH));
  assign count  = r_count;
  assign w_pop  = pop & ~empty & ~flush;
  assign w_push = push & (~full | w_pop) & ~flush;

  // Empty FIFO reads as zero regardless of stale storage
  assign dout = empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH (power of 2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/keypad_fifo.sv
// Memory-mapped keypad key buffer: DATA/STATUS/CTRL window around a sync_fifo,
// plus a registered key-available level and a sticky overflow flag.
module keypad_fifo
  import keypad_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [11:0] BASE  = 12'h900
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [11:0] address,
  input  logic        rd_stb,
  input  logic        wr_stb,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        key_avail,
  output logic        overflow
);

  localparam logic [11:0] A_DATA   = BASE + OFF_DATA;
  localparam logic [11:0] A_STATUS = BASE + OFF_STATUS;
  localparam logic [11:0] A_CTRL   = BASE + OFF_CTRL;

  reg_sel_e    w_sel;
  logic        w_pop;
  logic        w_flush;
  logic        w_stat_rd;
  logic        w_drop;
  logic        w_full;
  logic        w_empty;
  logic [3:0]  w_count;
  logic [3:0]  w_head;
  logic        w_unused;

  logic        r_overflow;
  logic        r_key_avail;

  // Only the flush bit of CTRL carries meaning
  assign w_unused = ^wdata[15:1];

  // Address decode into the register window
  always_comb begin
    w_sel = SEL_NONE;
    if      (address == A_DATA)   w_sel = SEL_DATA;
    else if (address == A_STATUS) w_sel = SEL_STATUS;
    else if (address == A_CTRL)   w_sel = SEL_CTRL;
  end

  assign w_pop     = rd_stb & (w_sel == SEL_DATA);
  assign w_stat_rd = rd_stb & (w_sel == SEL_STATUS);
  assign w_flush   = wr_stb & (w_sel == SEL_CTRL) & wdata[CTRL_FLUSH];
  // When full the FIFO is non-empty, so a DATA read always frees a slot
  assign w_drop    = key_valid & w_full & ~w_pop & ~w_flush;

  sync_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (key_valid),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (key_code),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Sticky overflow: flush clears, a dropped key sets (beats a STATUS-read clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_overflow <= 1'b0;
    else if (w_flush)   r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (w_stat_rd) r_overflow <= 1'b0;
  end

  // Key-available tracks the post-edge non-empty state as its own flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_key_avail <= 1'b0;
    else if (w_flush)                           r_key_avail <= 1'b0;
    else if (key_valid & (~w_full | w_pop))     r_key_avail <= 1'b1;
    else if (w_pop & (w_count == 4'd1))         r_key_avail <= 1'b0;
  end

  // Read mux; returns pre-update state during a strobed read
  always_comb begin
    rdata = 16'h0000;
    case (w_sel)
      SEL_DATA:   rdata = {12'h000, w_head};
      SEL_STATUS: rdata = status_word(~w_empty, w_full, r_overflow, w_count);
      default:    rdata = 16'h0000;
    endcase
  end

  assign key_avail = r_key_avail;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_fifo.sv
// Directed bench for keypad_fifo with a queue-based reference model and a
// per-cycle compare process, plus literal expectations from the register map.
module tb_keypad_fifo;

  localparam int          DEPTH    = 8;
  localparam logic [11:0] BASE     = 12'h900;
  localparam logic [11:0] A_DATA   = BASE;
  localparam logic [11:0] A_STATUS = BASE + 12'd1;
  localparam logic [11:0] A_CTRL   = BASE + 12'd2;
  localparam logic [11:0] A_OTHER  = BASE + 12'd3;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] address;
  logic        rd_stb;
  logic        wr_stb;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        key_avail;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  logic [3:0] mq[$];
  logic       m_ovf;

  keypad_fifo #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .address   (address),
    .rd_stb    (rd_stb),
    .wr_stb    (wr_stb),
    .wdata     (wdata),
    .rdata     (rdata),
    .key_avail (key_avail),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] exp_rdata(input logic [11:0] a);
    int n;
    logic [15:0] v;
    n = mq.size();
    v = 16'h0000;
    if (a == A_DATA) begin
      if (n > 0) v = {12'h000, mq[0]};
    end else if (a == A_STATUS) begin
      v[0]    = (n > 0);
      v[1]    = (n == DEPTH);
      v[2]    = m_ovf;
      v[11:8] = 4'(n);
    end
    return v;
  endfunction

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // compare DUT against the model every cycle, away from the rising edge
  always @(negedge clk) begin
    check16("cyc_rdata", rdata, exp_rdata(address));
    check16("cyc_key_avail", {15'h0, key_avail}, {15'h0, mq.size() != 0});
    check16("cyc_overflow", {15'h0, overflow}, {15'h0, m_ovf});
  end

  // one bus cycle: drive, let the edge happen, advance the model, stop at negedge+1
  task automatic cyc(input logic kv, input logic [3:0] kc, input logic [11:0] a,
                     input logic rd, input logic wr, input logic [15:0] wd);
    logic flush, pop, strd, set;
    key_valid = kv; key_code = kc; address = a; rd_stb = rd; wr_stb = wr; wdata = wd;
    flush = wr && (a == A_CTRL) && wd[0];
    pop   = rd && (a == A_DATA) && (mq.size() > 0);
    strd  = rd && (a == A_STATUS);
    set   = 1'b0;
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (kv) begin
          if (mq.size() < DEPTH) mq.push_back(kc);
          else set = 1'b1;
        end
        if (set) m_ovf = 1'b1;
        else if (strd) m_ovf = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    key_valid = 1'b0; rd_stb = 1'b0; wr_stb = 1'b0; wdata = 16'h0;
  endtask

  task automatic push(input logic [3:0] k);  cyc(1'b1, k, A_OTHER, 1'b0, 1'b0, 16'h0); endtask
  task automatic pop_data();                  cyc(1'b0, 4'h0, A_DATA, 1'b1, 1'b0, 16'h0); endtask
  task automatic rd_status();                 cyc(1'b0, 4'h0, A_STATUS, 1'b1, 1'b0, 16'h0); endtask

  // literal register peek (no strobes)
  task automatic peek(input string name, input logic [11:0] a, input logic [15:0] exp);
    address = a; rd_stb = 1'b0; wr_stb = 1'b0; key_valid = 1'b0;
    #1;
    check16(name, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; address = A_OTHER;
    rd_stb = 1'b0; wr_stb = 1'b0; wdata = 16'h0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // reset state
    peek("rst_status", A_STATUS, 16'h0000);
    peek("rst_data", A_DATA, 16'h0000);

    // single key in and out
    push(4'h5);
    peek("one_status", A_STATUS, 16'h0101);
    peek("one_data", A_DATA, 16'h0005);
    check16("one_avail", {15'h0, key_avail}, 16'h0001);
    pop_data();
    peek("one_pop_status", A_STATUS, 16'h0000);
    check16("one_pop_avail", {15'h0, key_avail}, 16'h0000);
    pop_data();  // pop on empty has no effect
    peek("empty_pop_status", A_STATUS, 16'h0000);

    // fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) push(4'(i));
    push(4'h9);
    peek("full_ovf_status", A_STATUS, 16'h0807);
    for (int i = 1; i <= 8; i++) begin
      peek("drain_data", A_DATA, 16'(i));
      pop_data();
    end
    peek("drained_data", A_DATA, 16'h0000);
    peek("drained_status", A_STATUS, 16'h0004);

    // STATUS read clears overflow, returning the pre-clear value
    rd_status();
    peek("ovf_cleared", A_STATUS, 16'h0000);

    // overflow set wins over same-cycle STATUS clear
    for (int i = 1; i <= 8; i++) push(4'(i));
    cyc(1'b1, 4'h9, A_STATUS, 1'b1, 1'b0, 16'h0);
    peek("set_wins", A_STATUS, 16'h0807);
    rd_status();
    peek("full_noovf", A_STATUS, 16'h0803);

    // push+pop while full: both happen, no overflow
    peek("pp_head", A_DATA, 16'h0001);
    cyc(1'b1, 4'hA, A_DATA, 1'b1, 1'b0, 16'h0);
    peek("pp_status", A_STATUS, 16'h0803);
    for (int i = 2; i <= 8; i++) begin
      peek("pp_drain", A_DATA, 16'(i));
      pop_data();
    end
    peek("pp_last", A_DATA, 16'h000A);
    pop_data();
    peek("pp_empty", A_STATUS, 16'h0000);

    // push+pop while empty: push only
    cyc(1'b1, 4'h3, A_DATA, 1'b1, 1'b0, 16'h0);
    peek("pe_status", A_STATUS, 16'h0101);
    pop_data();

    // ignored writes, then flush beating a push
    push(4'hB); push(4'hC); push(4'hD);
    cyc(1'b0, 4'h0, A_CTRL, 1'b0, 1'b1, 16'h0002);
    cyc(1'b0, 4'h0, A_DATA, 1'b0, 1'b1, 16'h0001);
    peek("ign_wr_status", A_STATUS, 16'h0301);
    peek("ctrl_reads_zero", A_CTRL, 16'h0000);
    cyc(1'b1, 4'hE, A_CTRL, 1'b0, 1'b1, 16'h0001);
    peek("flush_status", A_STATUS, 16'h0000);
    push(4'h7);
    peek("after_flush_head", A_DATA, 16'h0007);
    pop_data();

    // 4 entries with overflow set, stray address access, then async reset
    for (int i = 1; i <= 9; i++) push(4'(i));
    for (int i = 0; i < 4; i++) pop_data();
    peek("four_status", A_STATUS, 16'h0405);
    cyc(1'b0, 4'h0, A_OTHER, 1'b1, 1'b1, 16'hFFFF);
    peek("other_addr", A_OTHER, 16'h0000);
    peek("four_head", A_DATA, 16'h0005);
    #2;
    rst_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    check16("arst_avail", {15'h0, key_avail}, 16'h0000);
    check16("arst_ovf", {15'h0, overflow}, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 4'h0, A_OTHER, 1'b0, 1'b0, 16'h0);
    peek("post_rst_status", A_STATUS, 16'h0000);
    peek("post_rst_data", A_DATA, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
